// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the FFT frame sequencer.
// Holds the sequencer state encoding and the address bit-reversal.
package fft_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_UNLOAD
  } state_e;

  localparam int MAX_AW = 10;

  // Reverse all MAX_AW bits, then shift the low aw reversed bits into place.
  function automatic logic [MAX_AW-1:0] bitrev(
    input logic [MAX_AW-1:0] i,
    input int                aw
  );
    logic [MAX_AW-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_AW; b++) begin
      r[MAX_AW-1-b] = i[b];
    end
    return r >> (MAX_AW - aw);
  endfunction

endpackage

// File: rtl/fft_seq_out_fifo.sv
// Two-entry skid FIFO carrying an output sample and its last tag.
// Push and pop may occur in the same cycle.
module fft_seq_out_fifo
  import fft_seq_pkg::*;
#(
  parameter int DW = 33
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem_q [2];
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic [1:0]    count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q ^ push_i;
    rptr_d  = rptr_q ^ pop_i;
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller: loads N samples into FFT RAM, starts the FFT,
// then streams the N results out through a valid/ready port.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int W  = 16,
  localparam int AW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          bitrev_en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*W-1:0] in_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [2*W-1:0] mem_wdata,
  input  logic [2*W-1:0] mem_rdata,
  output logic          fft_start,
  input  logic          fft_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*W-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic [15:0]   frame_count
);

  localparam logic [AW:0] LAST = (AW+1)'(N - 1);
  localparam logic [AW:0] FULL = (AW+1)'(N);

  state_e        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic          brev_q, brev_d;
  logic          infl_q, infl_last_q;
  logic [15:0]   fc_q, fc_d;
  logic          live_q;
  logic          rd_issue;
  logic          load_ok;
  logic          pop;
  logic [1:0]    fifo_count;
  logic [2:0]    occ;
  logic [AW-1:0] brev_addr;
  logic [2*W:0]  fifo_dout;

  assign brev_addr = AW'(bitrev(MAX_AW'(idx_q[AW-1:0]), AW));
  // live_q keeps the input port closed while reset is applied.
  assign load_ok   = live_q &&
                     (state_q == S_IDLE || state_q == S_LOAD);
  assign in_ready  = load_ok;
  assign out_valid = (fifo_count != 2'd0);
  assign {out_last, out_data} = fifo_dout;
  assign pop       = out_valid & out_ready;
  assign occ       = {1'b0, fifo_count} - {2'b0, pop} + {2'b0, infl_q};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    brev_d    = brev_q;
    fc_d      = fc_q;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fft_start = 1'b0;
    rd_issue  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && load_ok) begin
          brev_d    = bitrev_en;
          mem_we    = 1'b1;
          mem_wdata = in_data;
          idx_d     = (AW+1)'(1);
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid && load_ok) begin
          mem_we    = 1'b1;
          mem_addr  = brev_q ? brev_addr : idx_q[AW-1:0];
          mem_wdata = in_data;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = S_START;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_START: begin
        fft_start = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (fft_done) state_d = S_UNLOAD;
      end
      S_UNLOAD: begin
        mem_addr = idx_q[AW-1:0];
        // Count the slot freed by this cycle's pop to sustain full rate.
        if (occ < 3'd2 && idx_q < FULL) begin
          rd_issue = 1'b1;
          idx_d    = idx_q + 1'b1;
        end
        if (pop && out_last) begin
          fc_d    = fc_q + 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      brev_q      <= 1'b0;
      fc_q        <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      brev_q      <= brev_d;
      fc_q        <= fc_d;
      infl_q      <= rd_issue;
      infl_last_q <= rd_issue && (idx_q == LAST);
      live_q      <= 1'b1;
    end
  end

  fft_seq_out_fifo #(
    .DW(2*W+1)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .push_i (infl_q),
    .din_i  ({infl_last_q, mem_rdata}),
    .pop_i  (pop),
    .dout_o (fifo_dout),
    .count_o(fifo_count)
  );

  assign busy        = (state_q != S_IDLE);
  assign frame_count = fc_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with RAM/FFT models and
// write/output scoreboards.
module tb_fft_frame_sequencer;

  localparam int N  = 16;
  localparam int W  = 16;
  localparam int AW = 4;
  localparam int DW = 2 * W;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          bitrev_en = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic          spur_done = 1'b0;
  logic          in_ready, mem_we, fft_start, fft_done;
  logic          out_valid, out_last, busy, model_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, out_data;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   frame_count;
  logic [DW-1:0] ram [N];
  int            fcnt = 0;

  int checks = 0;
  int failures = 0;
  wr_t          wq[$];
  logic [DW:0]  oq[$];
  logic [DW-1:0] expm [N];
  int  cyc = 0, last_we_cyc = -10;
  int  n_writes = 0, n_starts = 0, beats = 0;
  bit  post_load = 0, done_seen = 0, frame_done = 0;
  bit  prev_stall = 0, bp = 0;
  logic [DW:0] prev_beat = '0;

  always #5 CLK = ~CLK;

  fft_frame_sequencer #(.N(N), .W(W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .bitrev_en  (bitrev_en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .fft_start  (fft_start),
    .fft_done   (fft_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .frame_count(frame_count)
  );

  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(posedge CLK) begin
    if (fft_start) fcnt <= 20;
    else if (fcnt > 0) fcnt <= fcnt - 1;
  end
  assign model_done = (fcnt == 1);
  assign fft_done   = model_done | spur_done;

  function automatic int brv(input int i);
    int r = 0;
    for (int b = 0; b < AW; b++)
      if ((i & (1 << b)) != 0) r |= 1 << (AW - 1 - b);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    #1;
    out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    wr_t         w;
    logic [DW:0] e;
    @(negedge CLK);
    cyc++;
    if (model_done) done_seen = 1;
    if (mem_we) begin
      n_writes++;
      last_we_cyc = cyc;
      if (wq.size() == 0) begin
        chk("wr_unexpected", {mem_addr, mem_wdata}, 0);
      end else begin
        w = wq.pop_front();
        chk("wr", {mem_addr, mem_wdata}, {w.a, w.d});
      end
    end
    if (fft_start) begin
      n_starts++;
      chk("start_lat", cyc, last_we_cyc + 1);
      post_load = 1;
    end
    if (post_load) chk("closed", {in_ready, busy}, 2'b01);
    if (prev_stall) chk("stall_hold", {out_valid, out_last, out_data},
                        {1'b1, prev_beat});
    if (out_valid) begin
      chk("early_out", done_seen, 1);
      if (out_ready) begin
        beats++;
        if (oq.size() == 0) begin
          chk("out_unexpected", {out_last, out_data}, 0);
        end else begin
          e = oq.pop_front();
          chk("out", {out_last, out_data}, e);
        end
        if (out_last) begin
          frame_done = 1;
          post_load  = 0;
        end
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_beat  = {out_last, out_data};
  end

  task automatic run_frame(input bit brev, input bit toggle,
                           input bit gaps, input bit spur,
                           input logic [DW-1:0] seed,
                           input int exp_fc);
    int            j, c;
    logic [DW-1:0] d;
    int            a;
    frame_done = 0; done_seen = 0;
    n_writes = 0; n_starts = 0; beats = 0;
    j = 0; c = 0; d = '0;
    while (j < N) begin
      if (gaps && (c % 3 == 2)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        d = DW'(j) * 32'h0001_0001 ^ seed;
        a = brev ? brv(j) : j;
        wq.push_back('{a: AW'(a), d: d});
        expm[a] = d;
      end
      in_data   = d;
      bitrev_en = (j == 0 || !toggle) ? brev : c[0];
      spur_done = spur && (j == 5);
      if (in_valid) chk("in_ready_load", in_ready, 1);
      @(posedge CLK);
      #1;
      if (in_valid) j++;
      c++;
    end
    in_valid  = 1'b0;
    spur_done = 1'b0;
    bitrev_en = 1'b0;
    for (int k = 0; k < N; k++) oq.push_back({k == N - 1, expm[k]});
    for (int t = 0; t < 400 && !frame_done; t++) @(negedge CLK);
    chk("frame_done", frame_done, 1);
    chk("n_writes", n_writes, N);
    chk("n_starts", n_starts, 1);
    chk("beats", beats, N);
    chk("oq_empty", oq.size(), 0);
    @(negedge CLK);
    chk("frame_count", frame_count, exp_fc);
    chk("idle", {busy, in_ready, out_valid}, 3'b010);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_ctl", {in_ready, mem_we, fft_start, out_valid, out_last, busy},
        6'b0);
    chk("rst_mem", {mem_addr, mem_wdata}, 0);
    chk("rst_fc", frame_count, 0);
  endtask

  initial begin
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk_reset();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1);
    run_frame(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_0000, 2);
    bp = 1;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 32'h00A5_5A00, 3);
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 32'h7777_0001, 4);
    bp = 0;
    @(posedge CLK);
    #1;
    run_frame(1'b0, 1'b0, 1'b1, 1'b1, 32'hBEEF_0000, 5);

    for (int j = 0; j < 7; j++) begin
      in_valid  = 1'b1;
      in_data   = DW'(j) * 32'h0001_0001;
      wq.push_back('{a: AW'(j), d: in_data});
      @(posedge CLK);
      #1;
    end
    RST_N = 1'b0;
    #1;
    chk_reset();
    chk("rst_wq", wq.size(), 0);
    repeat (2) @(posedge CLK);
    #1;
    in_valid = 1'b0;
    RST_N    = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_fc_after", frame_count, 0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 32'h0F0F_0000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
